// File: rtl/pdm_playback_sequencer.sv
// Sample-playback controller: loads a small level table, then emits one PDM write per FRAME clocks.
// Optional build macro PDM_SEQ_LOOP_EN: repeat the table until stop instead of a single pass.
module pdm_playback_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5,
  parameter int FRAME = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  output logic [WIDTH-1:0]         pdm_value,
  output logic                     pdm_write,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FRAME);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    frame_cnt;
  logic [FW-1:0]    frame_next;
  logic [CW-1:0]    rd_inc;
  logic [AW-1:0]    rd_next;
  logic [AW-1:0]    start_ptr;
  logic             last_done;
  logic             tick;

  assign full       = (count == CW'(DEPTH));
  assign rd_inc     = {1'b0, rd_ptr} + CW'(1);
  assign rd_next    = (rd_inc == count) ? '0 : rd_inc[AW-1:0];
  assign start_ptr  = (count == CW'(1)) ? '0 : AW'(1);
  assign frame_next = (frame_cnt == FW'(FRAME - 1)) ? '0 : frame_cnt + FW'(1);
  assign tick       = (frame_cnt == '0);

  // rd_ptr has wrapped to 0 exactly when the frame just finished carried entry count-1.
`ifdef PDM_SEQ_LOOP_EN
  assign last_done = 1'b0;
`else
  assign last_done = (rd_ptr == '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && load && !clear && !full) begin
      mem[count[AW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pdm_value <= '0;
      pdm_write <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      frame_cnt <= '0;
    end else begin
      pdm_write <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            count <= '0;
          end else if (load && !full) begin
            count <= count + CW'(1);
          end
          // Uses the pre-edge count, so a same-cycle load cannot enable start.
          if (start && !stop && count != '0) begin
            state     <= PLAY;
            busy      <= 1'b1;
            rd_ptr    <= start_ptr;
            frame_cnt <= FW'(1);
            pdm_value <= mem[0];
            pdm_write <= 1'b1;
          end
        end
        PLAY: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            frame_cnt <= frame_next;
            if (tick) begin
              if (last_done) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                pdm_value <= mem[rd_ptr];
                pdm_write <= 1'b1;
                rd_ptr    <= rd_next;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_playback_sequencer.sv
// Bench for pdm_playback_sequencer: random tables and stops checked against a frame-level model.
// Honours PDM_SEQ_LOOP_EN the same way the design does.
module tb_pdm_playback_sequencer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 5;
  localparam int FRAME = 64;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PDM_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] pdm_value;
  logic             pdm_write;
  logic             busy;
  logic             full;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Scoreboard: expected strobe values and the cycle each must appear in.
  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];
  // Reference table contents as the model believes them to be.
  logic [WIDTH-1:0] tbl[$];

  pdm_playback_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FRAME(FRAME)) dut (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .clear(clear),
    .start(start), .stop(stop), .pdm_value(pdm_value), .pdm_write(pdm_write),
    .busy(busy), .full(full), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (pdm_write !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL strobe_unexpected: got write of %0d, expected no write (cycle %0d)",
                   pdm_value, cyc);
        end else begin
          chk("strobe_cycle", cyc, exp_cyc_q.pop_front());
          chk("strobe_value", pdm_value, exp_q.pop_front());
        end
      end
    end
  endtask

  // Drive one cycle of load (and optionally clear); clear beats load in the model.
  task automatic do_load(logic [WIDTH-1:0] v, bit clr);
    load = 1'b1;
    load_data = v;
    clear = clr;
    if (clr) tbl.delete();
    else if (tbl.size() < DEPTH) tbl.push_back(v);
    @(negedge clk);
    load = 1'b0;
    clear = 1'b0;
  endtask

  task automatic chk_count(string name);
    chk({name, "_count"}, count, tbl.size());
    chk({name, "_full"}, full, tbl.size() == DEPTH);
  endtask

  // Play the model table; stop_at < 0 means no stop (loop build picks a stop after a wrap).
  task automatic run_play(int stop_at, bit ign);
    int cnt, endoff, k, n;
    logic [WIDTH-1:0] last;
    cnt = tbl.size();
    if (LOOP && stop_at < 0) stop_at = (cnt + 2) * FRAME + 3;
    endoff = (stop_at < 0 || (!LOOP && stop_at > cnt * FRAME)) ? cnt * FRAME : stop_at;
    n = cyc + 1;
    last = '0;
    k = 0;
    while (k * FRAME < endoff) begin
      exp_q.push_back(tbl[k % cnt]);
      exp_cyc_q.push_back(n + k * FRAME);
      last = tbl[k % cnt];
      k++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= endoff; j++) begin
      if (j == endoff) chk("busy_before_end", busy, 1);
      stop = (j == stop_at);
      if (ign && j < endoff && $urandom_range(0, 3) == 0) begin
        load = 1'($urandom_range(0, 1));
        clear = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        load_data = WIDTH'($urandom);
      end else begin
        load = 1'b0;
        clear = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
    {load, clear, start, stop} = '0;
    chk("busy_after_end", busy, 0);
    chk("hold_value", pdm_value, last);
    chk("count_after_play", count, cnt);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    chk("rst_value", pdm_value, 0);
    chk("rst_write", pdm_write, 0);
    chk("rst_busy", busy, 0);
    chk_count("rst");
    reset = 1'b0;

    // Start with an empty table must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (FRAME + 4) @(negedge clk);
    chk("empty_start_busy", busy, 0);

    // Directed four-entry table.
    do_load(5'h08, 1'b0);
    do_load(5'h1A, 1'b0);
    do_load(5'h0F, 1'b0);
    do_load(5'h04, 1'b0);
    chk_count("four");
    run_play(-1, 1'b0);
    repeat (3) @(negedge clk);

    // Stop on a tick edge: no strobe, value holds the second entry.
    run_play(2 * FRAME, 1'b0);
    chk("stop_value_1a", pdm_value, 5'h1A);
    repeat (5) @(negedge clk);

    // start together with stop in IDLE stays idle.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (FRAME + 2) @(negedge clk);
    chk("start_stop_idle", busy, 0);

    // Fill past capacity: ninth load dropped.
    do_load(WIDTH'($urandom), 1'b1);
    chk_count("cleared");
    repeat (DEPTH + 1) do_load(WIDTH'($urandom), 1'b0);
    chk_count("overfill");
    run_play(-1, 1'b1);
    do_load(WIDTH'($urandom), 1'b1);
    chk_count("clear_after_full");

    // Two-entry table: alternation (and wrap in the loop build).
    do_load(5'h03, 1'b0);
    do_load(5'h1F, 1'b0);
    chk_count("two");
    run_play(7 * FRAME, 1'b1);
    repeat (2) @(negedge clk);

    // Randomised tables, random stops, random ignored inputs.
    repeat (6) begin
      int n_ld, st;
      do_load(WIDTH'($urandom), 1'b1);
      n_ld = $urandom_range(1, DEPTH);
      repeat (n_ld) do_load(WIDTH'($urandom), 1'b0);
      chk_count("rand_load");
      st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n_ld * FRAME) : -1;
      run_play(st, 1'b1);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    // Reset in the middle of playback.
    do_load(WIDTH'($urandom), 1'b1);
    do_load(5'h11, 1'b0);
    do_load(5'h02, 1'b0);
    exp_q.push_back(5'h11);
    exp_cyc_q.push_back(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tbl.delete();
    chk("midrst_value", pdm_value, 0);
    chk("midrst_write", pdm_write, 0);
    chk("midrst_busy", busy, 0);
    chk_count("midrst");
    repeat (FRAME + 4) @(negedge clk);
    chk("midrst_no_resume", busy, 0);

    chk("pending_strobes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
